spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16: maximum transfer length in bits.
REQ-002 SHALL have parameter LEN_W, default 4: width of len_m1. DATA_W SHALL equal 2**LEN_W.
REQ-003 SHALL have parameter DIV_W, default 8: width of div.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  transfer request; accepted only when busy=0.
REQ-007 tx_data  input  DATA_W  transmit word, right-aligned, sent MSB-first from bit len_m1.
REQ-008 len_m1  input  LEN_W  transfer length minus one; N = len_m1+1 bits.
REQ-009 div  input  DIV_W  SCK half-period minus one; H = div+1 clk cycles.
REQ-010 busy  output  1  transfer in progress.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 rx_data  output  DATA_W  received word, right-aligned, first bit received in bit N-1, upper bits zero.
REQ-013 sck  output  1  SPI clock, idle low (mode 0).
REQ-014 ss  output  1  slave select, active-low, idle high.
REQ-015 mosi  output  1  serial data out, idle high.
REQ-016 miso  input  1  serial data in.

Function
REQ-017 SHALL implement states IDLE, SETUP, HIGH, LOW, HOLD and GAP; every non-IDLE state SHALL last exactly H clk cycles, timed by a DIV_W-bit down-counter.
REQ-018 IDLE: start=1 SHALL capture tx_data, len_m1 and div, load the bit counter with N, and enter SETUP; start SHALL be ignored in all other states.
REQ-019 SETUP: ss=0, sck=0, mosi=tx_data[len_m1]; all three SHALL be visible in the first cycle after acceptance.
REQ-020 SETUP->HIGH: sck SHALL rise. HIGH lasts H cycles.
REQ-021 HIGH end: sck SHALL fall and miso SHALL be shifted into the LSB of the receive shift register on that same edge.
REQ-022 HIGH end with bits remaining: mosi SHALL advance to the next lower bit on the falling edge, and the FSM SHALL enter LOW; LOW end SHALL return to HIGH.
REQ-023 HIGH end on the last bit: the FSM SHALL enter HOLD with ss=0, sck=0, mosi=1.
REQ-024 HOLD end: ss SHALL rise and the FSM SHALL enter GAP with ss=1, sck=0, mosi=1.
REQ-025 GAP end: the FSM SHALL return to IDLE, load rx_data from the shift register, and pulse done=1 for exactly the first IDLE cycle.
REQ-026 Exactly N rising sck edges SHALL occur per transfer.
REQ-027 busy SHALL be 1 for exactly (2N+2)*H cycles per transfer.
REQ-028 rx_data SHALL change only on the done cycle and SHALL hold its value otherwise.
REQ-029 start=1 during the done cycle SHALL be accepted (back-to-back transfer); ss SHALL then stay high for exactly H+1 cycles between transfers.
REQ-030 div=0 SHALL be legal, giving sck = clk/2.
REQ-031 len_m1=0 SHALL give a 1-bit transfer.
REQ-032 Changes to tx_data, len_m1 or div while busy SHALL NOT affect the transfer in progress.

Reset
REQ-033 rst_n=0 at a clk edge SHALL force IDLE, ss=1, sck=0, mosi=1, busy=0, done=0, rx_data=0 and clear all counters and the shift register.
REQ-034 Reset mid-transfer SHALL abort the transfer, producing no done pulse and no rx_data update; ss SHALL be high from the next cycle.
REQ-035 A start presented in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-036 Reset: hold rst_n=0 for 2 cycles mid-transfer -> ss=1, sck=0, mosi=1, busy=0, done=0, rx_data=16'h0000; no done follows.
REQ-037 Loopback: miso tied to mosi, div=0, len_m1=15, tx_data=16'hA5C3 -> 16 sck rising edges, busy for 34 cycles, done pulse, rx_data=16'hA5C3.
REQ-038 Timing: div=3, len_m1=7, tx_data=16'h0081, miso=1 -> sck high for 4 cycles and low for 4 cycles per bit, mosi sequence 1,0,0,0,0,0,0,1, busy for 72 cycles, rx_data=16'h00FF.
REQ-039 Ignore while busy: raise start with tx_data=16'hFFFF mid-transfer -> no effect; the original transfer completes with its captured data and exactly one done pulse.
REQ-040 Back-to-back: start held high, div=1, len_m1=0 -> each transfer has busy for 8 cycles, ss high for 3 cycles between transfers, and one done per transfer.
REQ-041 1-bit: len_m1=0, miso=1, div=0 -> one sck pulse, busy for 4 cycles, rx_data=16'h0001.

Source files
------------

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, MSB-first, runtime length and SCK divider
module spi_master #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [LEN_W-1:0]  len_m1,
    input  logic [DIV_W-1:0]  div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_r;
    logic [LEN_W:0]    bit_cnt;
    logic [LEN_W-1:0]  bit_idx;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] rx_sh;
    logic              tick;

    // every non-idle state lasts div+1 cycles; tick marks its final cycle
    assign tick    = (cnt == '0);
    assign bit_idx = LEN_W'(bit_cnt - (LEN_W+1)'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_r   <= '0;
            bit_cnt <= '0;
            tx_r    <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    tx_r    <= tx_data;
                    div_r   <= div;
                    cnt     <= div;
                    bit_cnt <= {1'b0, len_m1} + (LEN_W+1)'(1);
                    rx_sh   <= '0;
                end
            end else begin
                cnt <= tick ? div_r : cnt - DIV_W'(1);
                // falling SCK edge: sample miso and advance to the next bit
                if (state == HIGH && tick) begin
                    rx_sh   <= {rx_sh[DATA_W-2:0], miso};
                    bit_cnt <= bit_cnt - (LEN_W+1)'(1);
                end
                if (state == GAP && tick) begin
                    rx_data <= rx_sh;
                    done    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        ss        = 1'b0;
        sck       = 1'b0;
        mosi      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                ss   = 1'b1;
                if (start) state_nxt = SETUP;
            end
            SETUP: begin
                mosi = tx_r[bit_idx];
                if (tick) state_nxt = HIGH;
            end
            HIGH: begin
                sck  = 1'b1;
                mosi = tx_r[bit_idx];
                if (tick) state_nxt = (bit_cnt == (LEN_W+1)'(1)) ? HOLD : LOW;
            end
            LOW: begin
                mosi = tx_r[bit_idx];
                if (tick) state_nxt = HIGH;
            end
            HOLD: begin
                if (tick) state_nxt = GAP;
            end
            GAP: begin
                ss = 1'b1;
                if (tick) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
                ss        = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized and directed checks of spi_master against a transfer-level model
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] tx_data;
    logic [3:0]  len_m1;
    logic [7:0]  div;
    logic        busy;
    logic        done;
    logic [15:0] rx_data;
    logic        sck;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic        miso_drv;
    bit          loop_mode;

    int checks   = 0;
    int failures = 0;

    assign miso = loop_mode ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(16), .LEN_W(4), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .len_m1(len_m1), .div(div), .busy(busy), .done(done),
        .rx_data(rx_data), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer; the slave answers resp MSB-first, or echoes mosi in loop mode.
    // Inputs are scrambled and start is pulsed randomly while busy.
    task automatic do_xfer(input string tag, input logic [15:0] tx, input logic [3:0] lm1,
                           input logic [7:0] dv, input bit lp, input logic [15:0] resp);
        int n, h, cyc, busy_cnt, rises, hi_run, lo_run, bad_hi, bad_lo, done_cnt, post, rx_changes;
        logic [31:0] mask;
        logic [15:0] mosi_word, rx_got, rx_prev, exp_rx;
        logic prev_sck;
        n = int'(lm1) + 1;
        h = int'(dv) + 1;
        mask = (32'd1 << n) - 32'd1;
        exp_rx = lp ? (tx & mask[15:0]) : (resp & mask[15:0]);
        cyc = 0; busy_cnt = 0; rises = 0; hi_run = 0; lo_run = 0; bad_hi = 0; bad_lo = 0;
        done_cnt = 0; post = 0; rx_changes = 0; mosi_word = '0; rx_got = '0; prev_sck = 1'b0;
        loop_mode = lp;
        miso_drv = 1'b0;
        @(negedge clk);
        rx_prev = rx_data;
        tx_data = tx; len_m1 = lm1; div = dv; start = 1'b1;
        while (cyc < 20000 && post < 4) begin
            @(negedge clk);
            if (cyc == 0) begin
                check({tag, "_setup_ss"},   32'(ss),   32'd0);
                check({tag, "_setup_sck"},  32'(sck),  32'd0);
                check({tag, "_setup_mosi"}, 32'(mosi), 32'(tx[lm1]));
            end
            if (busy) busy_cnt++;
            if (sck && !prev_sck) begin
                if (rises > 0 && lo_run != h) bad_lo++;
                rises++;
                hi_run = 0;
                mosi_word = {mosi_word[14:0], mosi};
                if (n - rises >= 0) miso_drv = resp[n - rises];
            end
            if (!sck && prev_sck) begin
                if (hi_run != h) bad_hi++;
                lo_run = 0;
            end
            if (sck) hi_run++; else lo_run++;
            if (!done && rx_data !== rx_prev) rx_changes++;
            rx_prev = rx_data;
            if (done) begin
                done_cnt++;
                rx_got = rx_data;
            end
            if (done) start = 1'b0;
            else if (busy) begin
                start = 1'($urandom);
                tx_data = 16'($urandom);
                len_m1 = 4'($urandom);
                div = 8'($urandom);
            end else start = 1'b0;
            prev_sck = sck;
            cyc++;
            if (done_cnt > 0) post++;
        end
        check({tag, "_rises"},      32'(rises),      32'(n));
        check({tag, "_busy_cycles"}, 32'(busy_cnt),  32'((2 * n + 2) * h));
        check({tag, "_done_count"}, 32'(done_cnt),   32'd1);
        check({tag, "_rx_data"},    32'(rx_got),     32'(exp_rx));
        check({tag, "_mosi_bits"},  32'(mosi_word),  tx & mask);
        check({tag, "_sck_high"},   32'(bad_hi),     32'd0);
        check({tag, "_sck_low"},    32'(bad_lo),     32'd0);
        check({tag, "_rx_stable"},  32'(rx_changes), 32'd0);
    endtask

    initial begin
        int busy_run, ss_run, done_cnt, falls;
        int busy_runs[$];
        int ss_runs[$];
        bit seen_ss_fall;
        logic prev_busy, prev_ss;

        rst_n = 1'b0; start = 1'b1; tx_data = 16'hFFFF; len_m1 = '0; div = '0;
        miso_drv = 1'b0; loop_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ss",   32'(ss),      32'd1);
        check("reset_sck",  32'(sck),     32'd0);
        check("reset_mosi", 32'(mosi),    32'd1);
        check("reset_busy", 32'(busy),    32'd0);
        check("reset_done", 32'(done),    32'd0);
        check("reset_rx",   32'(rx_data), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        do_xfer("loopback", 16'hA5C3, 4'd15, 8'd0, 1'b1, 16'h0000);
        do_xfer("timing",   16'h0081, 4'd7,  8'd3, 1'b0, 16'hFFFF);
        do_xfer("one_bit",  16'h0000, 4'd0,  8'd0, 1'b0, 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            do_xfer($sformatf("rand%0d", i), 16'($urandom), 4'($urandom),
                    8'($urandom_range(0, 5)), 1'($urandom), 16'($urandom));
        end

        // back-to-back: start held high across done cycles
        loop_mode = 1'b0;
        busy_run = 0; ss_run = 0; done_cnt = 0; falls = 0; seen_ss_fall = 1'b0;
        prev_busy = 1'b0; prev_ss = 1'b1;
        @(negedge clk);
        div = 8'd1; len_m1 = 4'd0; tx_data = 16'h0001; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) busy_run++;
            else if (prev_busy) begin busy_runs.push_back(busy_run); busy_run = 0; end
            if (ss) ss_run++;
            else if (prev_ss) begin
                if (seen_ss_fall) ss_runs.push_back(ss_run);
                seen_ss_fall = 1'b1;
                ss_run = 0;
            end
            if (done) done_cnt++;
            prev_busy = busy;
            prev_ss = ss;
        end
        start = 1'b0;
        check("b2b_transfers", 32'(busy_runs.size() >= 3), 32'd1);
        check("b2b_done_count", 32'(done_cnt), 32'(busy_runs.size()));
        foreach (busy_runs[k]) check($sformatf("b2b_busy%0d", k), 32'(busy_runs[k]), 32'd8);
        check("b2b_gaps", 32'(ss_runs.size() >= 2), 32'd1);
        foreach (ss_runs[k]) check($sformatf("b2b_ss_high%0d", k), 32'(ss_runs[k]), 32'd3);
        repeat (20) @(negedge clk);

        // reset in the middle of a transfer, with start asserted alongside it
        do_xfer("pre_reset", 16'h3C5A, 4'd15, 8'd0, 1'b1, 16'h0000);
        @(negedge clk);
        tx_data = 16'h1234; len_m1 = 4'd15; div = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        check("abort_ss_next", 32'(ss), 32'd1);
        @(negedge clk);
        check("abort_ss",   32'(ss),      32'd1);
        check("abort_sck",  32'(sck),     32'd0);
        check("abort_mosi", 32'(mosi),    32'd1);
        check("abort_busy", 32'(busy),    32'd0);
        check("abort_done", 32'(done),    32'd0);
        check("abort_rx",   32'(rx_data), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        done_cnt = 0; busy_run = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_run++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle",    32'(busy_run), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
